// File: rtl/comb_bist_capture.sv
// Self-test capture engine: walks every stimulus pattern through a combinational block,
// checks that each response has settled and compacts the responses into a 16-bit MISR.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for start; results of an aborted run are held
// ST_SETTLE | pattern applied, counting settle cycles, response snapshot last
// ST_SAMPLE | response compared to snapshot and folded into the signature
// ST_DONE   | all patterns applied; results and done held until next start
module comb_bist_capture #(
    parameter int          PAT_W  = 13,
    parameter int          RESP_W = 5,
    parameter int          SETTLE = 4,
    parameter logic [15:0] POLY   = 16'h1021,
    parameter logic [15:0] SEED   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [PAT_W-1:0]  pat_out,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic [15:0]       signature,
    output logic [PAT_W:0]    unstable_cnt,
    output logic [PAT_W-1:0]  first_unstable,
    output logic              first_unstable_vld
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [PAT_W-1:0] PAT_LAST    = '1;
    localparam logic [PAT_W:0]   UCNT_SAT    = {1'b1, {PAT_W{1'b0}}};
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [3:0]          settle_cnt_q, settle_cnt_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [RESP_W-1:0]   resp_a_q, resp_a_d;
    logic [15:0]         sig_q, sig_d;
    logic [PAT_W:0]      ucnt_q, ucnt_d;
    logic [PAT_W-1:0]    first_q, first_d;
    logic                first_vld_q, first_vld_d;

    logic [15:0]         resp_ext;
    logic [15:0]         misr_next;

    assign resp_ext  = 16'(resp_in);
    assign misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ resp_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            pat_q        <= '0;
            resp_a_q     <= '0;
            sig_q        <= SEED;
            ucnt_q       <= '0;
            first_q      <= '0;
            first_vld_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            pat_q        <= pat_d;
            resp_a_q     <= resp_a_d;
            sig_q        <= sig_d;
            ucnt_q       <= ucnt_d;
            first_q      <= first_d;
            first_vld_q  <= first_vld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        pat_d        = pat_q;
        resp_a_d     = resp_a_q;
        sig_d        = sig_q;
        ucnt_d       = ucnt_q;
        first_d      = first_q;
        first_vld_d  = first_vld_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    pat_d        = '0;
                    sig_d        = SEED;
                    ucnt_d       = '0;
                    first_vld_d  = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        resp_a_d = resp_in;
                        state_d  = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    sig_d = misr_next;
                    if (resp_in != resp_a_q) begin
                        if (ucnt_q != UCNT_SAT) begin
                            ucnt_d = ucnt_q + 1'b1;
                        end
                        if (!first_vld_q) begin
                            first_d     = pat_q;
                            first_vld_d = 1'b1;
                        end
                    end
                    if (pat_q == PAT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        pat_d        = pat_q + 1'b1;
                        settle_cnt_d = '0;
                        state_d      = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pat_out            = pat_q;
    assign signature          = sig_q;
    assign unstable_cnt       = ucnt_q;
    assign first_unstable     = first_q;
    assign first_unstable_vld = first_vld_q;
    assign busy               = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done               = (state_q == ST_DONE);

endmodule

// File: tb/tb_comb_bist_capture.sv
// Directed bench for comb_bist_capture: expected run results are queued at start
// from a bench-side MISR model and popped when done rises.
module tb_comb_bist_capture;

    localparam int          PW     = 9;
    localparam int          RW     = 5;
    localparam int          SET    = 4;
    localparam logic [15:0] POLY   = 16'h1021;
    localparam logic [15:0] SEED   = 16'hFFFF;
    localparam int          CPP    = SET + 1;
    localparam int          NPAT   = 1 << PW;
    localparam int          RUN    = NPAT * CPP;
    localparam int          FLIP_P = 'h155;

    localparam int M_ZERO = 0;
    localparam int M_PAT  = 1;
    localparam int M_INV  = 2;
    localparam int M_FLIP = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [PW-1:0] pat_out;
    logic [RW-1:0] resp_in;
    logic          busy;
    logic          done;
    logic [15:0]   signature;
    logic [PW:0]   unstable_cnt;
    logic [PW-1:0] first_unstable;
    logic          first_unstable_vld;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]   sig;
        logic [PW:0]   ucnt;
        logic [PW-1:0] first;
        logic          vld;
    } exp_t;

    exp_t sb_q[$];

    comb_bist_capture #(
        .PAT_W (PW),
        .RESP_W(RW),
        .SETTLE(SET),
        .POLY  (POLY),
        .SEED  (SEED)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .abort             (abort),
        .pat_out           (pat_out),
        .resp_in           (resp_in),
        .busy              (busy),
        .done              (done),
        .signature         (signature),
        .unstable_cnt      (unstable_cnt),
        .first_unstable    (first_unstable),
        .first_unstable_vld(first_unstable_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [RW-1:0] w);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ POLY;
        return n ^ {11'd0, w};
    endfunction

    // Response driven in cycle k of a run (cycle 0 is the first SETTLE cycle).
    function automatic logic [RW-1:0] resp_for(input int mode, input int k);
        int p;
        int ph;
        logic [31:0] pv;
        p  = k / CPP;
        ph = k % CPP;
        pv = 32'(p);
        case (mode)
            M_PAT:   return pv[RW-1:0];
            M_INV:   return (k % 2 == 1) ? 5'h1F : 5'h00;
            M_FLIP:  return (p == FLIP_P && ph == CPP - 1) ? 5'h1F : 5'h00;
            default: return 5'h00;
        endcase
    endfunction

    function automatic exp_t model(input int mode, input int npat);
        exp_t e;
        logic [RW-1:0] w;
        logic [RW-1:0] a;
        e.sig   = SEED;
        e.ucnt  = '0;
        e.first = '0;
        e.vld   = 1'b0;
        for (int p = 0; p < npat; p++) begin
            a     = resp_for(mode, p * CPP + CPP - 2);
            w     = resp_for(mode, p * CPP + CPP - 1);
            e.sig = misr_step(e.sig, w);
            if (w != a) begin
                if (e.ucnt != (PW+1)'(NPAT)) e.ucnt = e.ucnt + 1'b1;
                if (!e.vld) begin
                    e.first = PW'(p);
                    e.vld   = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // Entered at a negedge; returns at the negedge of cycle k0+n.
    task automatic drive_cycles(input int mode, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) begin
            resp_in = resp_for(mode, k);
            @(negedge clk);
        end
    endtask

    task automatic start_run(input int mode);
        resp_in = '0;
        start   = 1'b1;
        sb_q.push_back(model(mode, NPAT));
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_pat0", 32'(pat_out), 32'd0);
    endtask

    task automatic finish_run(input int mode, input string tag);
        exp_t e;
        drive_cycles(mode, 0, RUN - 1);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        drive_cycles(mode, RUN - 1, 1);
        check({tag, "_done_rise"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_sb_size"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_sig"}, 32'(signature), 32'(e.sig));
            check({tag, "_ucnt"}, 32'(unstable_cnt), 32'(e.ucnt));
            check({tag, "_vld"}, 32'(first_unstable_vld), 32'(e.vld));
            if (e.vld) check({tag, "_first"}, 32'(first_unstable), 32'(e.first));
        end
        resp_in = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pat"}, 32'(pat_out), 32'd0);
        check({tag, "_sig"}, 32'(signature), 32'(SEED));
        check({tag, "_ucnt"}, 32'(unstable_cnt), 32'd0);
        check({tag, "_first"}, 32'(first_unstable), 32'd0);
        check({tag, "_vld"}, 32'(first_unstable_vld), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        exp_t part;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        resp_in = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        start_run(M_ZERO);
        finish_run(M_ZERO, "zero");
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done), 32'd1);

        start_run(M_PAT);
        finish_run(M_PAT, "pat");

        start_run(M_INV);
        finish_run(M_INV, "inv");

        start_run(M_FLIP);
        finish_run(M_FLIP, "flip");

        // reset in the middle of pattern 100, then a clean rerun
        start_run(M_PAT);
        drive_cycles(M_PAT, 0, 100 * CPP + 1);
        check("mid_pat100", 32'(pat_out), 32'd100);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        sb_q.delete();
        resp_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(M_PAT);
        finish_run(M_PAT, "rerun");

        // start while busy is ignored; abort+start together at pattern 10 aborts
        start_run(M_ZERO);
        drive_cycles(M_ZERO, 0, 5 * CPP + 1);
        start = 1'b1;
        drive_cycles(M_ZERO, 5 * CPP + 1, 1);
        start = 1'b0;
        check("busy_start_pat", 32'(pat_out), 32'd5);
        check("busy_start_busy", 32'(busy), 32'd1);
        drive_cycles(M_ZERO, 5 * CPP + 2, 5 * CPP - 1);
        check("pre_abort_pat", 32'(pat_out), 32'd10);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        part = model(M_ZERO, 10);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pat", 32'(pat_out), 32'd10);
        check("abort_sig", 32'(signature), 32'(part.sig));
        repeat (2) @(negedge clk);
        check("idle_hold_busy", 32'(busy), 32'd0);
        check("idle_hold_pat", 32'(pat_out), 32'd10);
        void'(sb_q.pop_front());
        start_run(M_ZERO);
        finish_run(M_ZERO, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
